// File: rtl/alu_issue.sv
// Issue stage in front of the ALU: decodes OP / OP-IMM into ALU controls and operands behind a 2-entry skid buffer.
// Optional writeback operand bypass into captured and held entries is enabled with `define BYPASS_EN.

package alu_issue_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef struct packed {
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       alu_sel;
        logic       wr_en;
        logic       illegal;
    } alu_ctrl_t;

endpackage

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic              out_alu_sel,
    output logic [XLEN-1:0]   out_x,
    output logic [XLEN-1:0]   out_y,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr_en,
    output logic              out_illegal
);

    localparam int unsigned IMM_W = 12;

    typedef struct packed {
        alu_ctrl_t         ctrl;
        logic [XLEN-1:0]   x;
        logic [XLEN-1:0]   y;
        logic [REG_AW-1:0] rd;
`ifdef BYPASS_EN
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
`endif
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    entry_t     dec;
    entry_t     dec_b;
    entry_t     main_b;
    entry_t     skid_b;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_v_q, main_v_d;
    logic   skid_v_q, skid_v_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   consume;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Decode of the incoming instruction; illegal encodings collapse to an all-zero op flagged illegal
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec.ctrl.alu_sel = 1'b1;
                dec.ctrl.funct3  = f3;
                dec.x            = in_rs1_val;
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
                    dec.y           = XLEN'(in_instr[24:20]);
                    dec.ctrl.funct7 = f7;
                    legal = (f7 == F7_ZERO) || (f3 == F3_SRL_SRA && f7 == F7_ALT);
                end else begin
                    dec.y = {{(XLEN-IMM_W){in_instr[31]}}, in_instr[31:20]};
                    legal = 1'b1;
                end
`ifdef BYPASS_EN
                dec.use_rs1 = 1'b1;
`endif
            end
            OPC_OP: begin
                dec.ctrl.alu_sel = 1'b0;
                dec.ctrl.funct3  = f3;
                dec.ctrl.funct7  = f7;
                dec.x            = in_rs1_val;
                dec.y            = in_rs2_val;
                legal = (f7 == F7_ZERO) ||
                        (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
`ifdef BYPASS_EN
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
`endif
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec.rd         = REG_AW'(in_instr[11:7]);
            dec.ctrl.wr_en = (in_instr[11:7] != 5'd0);
`ifdef BYPASS_EN
            dec.rs1 = REG_AW'(in_instr[19:15]);
            dec.rs2 = REG_AW'(in_instr[24:20]);
`endif
        end else begin
            dec              = '0;
            dec.ctrl.illegal = 1'b1;
        end
    end

`ifdef BYPASS_EN
    // Replace register operands whose source matches the current writeback
    function automatic entry_t apply_wb(input entry_t e, input logic v,
                                        input logic [REG_AW-1:0] r,
                                        input logic [XLEN-1:0] d);
        entry_t o;
        o = e;
        if (v && r != '0) begin
            if (o.use_rs1 && o.rs1 == r) o.x = d;
            if (o.use_rs2 && o.rs2 == r) o.y = d;
        end
        return o;
    endfunction

    always_comb begin
        dec_b  = apply_wb(dec, wb_valid, wb_rd, wb_data);
        main_b = apply_wb(main_q, wb_valid, wb_rd, wb_data);
        skid_b = apply_wb(skid_q, wb_valid, wb_rd, wb_data);
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data, in_instr[19:15]};

    always_comb begin
        dec_b  = dec;
        main_b = main_q;
        skid_b = skid_q;
    end
`endif

    // Skid buffer: main feeds the output, skid absorbs the op accepted while main is stalled
    always_comb begin
        main_d   = main_b;
        skid_d   = skid_b;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        accept   = in_valid && in_ready_q;
        consume  = main_v_q && out_ready;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d   = '0;
            skid_d   = '0;
        end else if (consume) begin
            if (skid_v_q) begin
                main_d   = skid_b;
                main_v_d = 1'b1;
                skid_v_d = accept;
                if (accept) skid_d = dec_b;
            end else begin
                main_v_d = accept;
                if (accept) main_d = dec_b;
            end
        end else if (accept) begin
            if (!main_v_q) begin
                main_d   = dec_b;
                main_v_d = 1'b1;
            end else begin
                skid_d   = dec_b;
                skid_v_d = 1'b1;
            end
        end

        in_ready_d = !skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_v_q;
    assign out_funct3  = main_q.ctrl.funct3;
    assign out_funct7  = main_q.ctrl.funct7;
    assign out_alu_sel = main_q.ctrl.alu_sel;
    assign out_x       = main_q.x;
    assign out_y       = main_q.y;
    assign out_rd      = main_q.rd;
    assign out_wr_en   = main_q.ctrl.wr_en;
    assign out_illegal = main_q.ctrl.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_issue;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic              out_alu_sel;
    logic [XLEN-1:0]   out_x;
    logic [XLEN-1:0]   out_y;
    logic [REG_AW-1:0] out_rd;
    logic              out_wr_en;
    logic              out_illegal;

    alu_issue #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_funct3 (out_funct3),
        .out_funct7 (out_funct7),
        .out_alu_sel(out_alu_sel),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_rd     (out_rd),
        .out_wr_en  (out_wr_en),
        .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        sel;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference decode straight from the ISA rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] fn3;
        logic [6:0] fn7;
        logic signed [11:0] imm;
        bit shift;
        bit ok;
        opc = ins[6:0];
        fn3 = ins[14:12];
        fn7 = ins[31:25];
        imm = ins[31:20];
        shift = (fn3 == 3'd1) || (fn3 == 3'd5);
        e.f3 = 0; e.f7 = 0; e.sel = 0; e.x = 0; e.y = 0; e.rd = 0;
        e.wr = 0; e.ill = 1; e.rs1 = 0; e.rs2 = 0; e.u1 = 0; e.u2 = 0;
        ok = 0;
        if (opc == 7'h13) begin
            ok = shift ? (fn7 == 7'h00 || (fn3 == 3'd5 && fn7 == 7'h20)) : 1;
            if (ok) begin
                e.sel = 1; e.f3 = fn3; e.x = a;
                e.y   = shift ? {27'd0, ins[24:20]} : 32'(imm);
                e.f7  = shift ? fn7 : 7'd0;
                e.u1  = 1;
            end
        end else if (opc == 7'h33) begin
            ok = (fn7 == 7'h00) || (fn7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5));
            if (ok) begin
                e.f3 = fn3; e.f7 = fn7; e.x = a; e.y = b; e.u1 = 1; e.u2 = 1;
            end
        end
        if (ok) begin
            e.ill = 0;
            e.rd  = ins[11:7];
            e.wr  = (ins[11:7] != 0);
            e.rs1 = ins[19:15];
            e.rs2 = ins[24:20];
        end
        return e;
    endfunction

    function automatic logic [127:0] pay(input exp_t e);
        return 128'({e.f3, e.f7, e.sel, e.x, e.y, e.rd, e.wr, e.ill});
    endfunction

    function automatic logic [127:0] dut_pay();
        return 128'({out_funct3, out_funct7, out_alu_sel, out_x, out_y, out_rd, out_wr_en, out_illegal});
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        if (q.size() > 0) chk("payload", dut_pay(), pay(q[0]));
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input bit ordy, input bit fl);
        in_valid   = v;
        in_instr   = ins;
        in_rs1_val = a;
        in_rs2_val = b;
        out_ready  = ordy;
        flush      = fl;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
    endtask

    // One clock: update the model from the pre-edge inputs, then check at the following falling edge
    task automatic step(output bit acc);
        bit cons;
        acc  = in_valid && (q.size() < 2);
        cons = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            acc = 0;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(in_instr, in_rs1_val, in_rs2_val));
        end
`ifdef BYPASS_EN
        if (wb_valid && wb_rd != 0) begin
            foreach (q[i]) begin
                if (q[i].u1 && q[i].rs1 == wb_rd) q[i].x = wb_data;
                if (q[i].u2 && q[i].rs2 == wb_rd) q[i].y = wb_data;
            end
        end
`endif
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            drive(0, 32'h0, 0, 0, 1, 0);
            step(acc);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] fn7;
        int r;
        r = int'($urandom_range(0, 7));
        opc = (r < 3) ? 7'h13 : (r < 6) ? 7'h33 : 7'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    fn7 = 7'h00;
            2:       fn7 = 7'h20;
            default: fn7 = 7'($urandom);
        endcase
        if (r == 7) return $urandom;
        return {fn7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), opc};
    endfunction

    logic [31:0] ops [4];
    bit          acc;
    int          idx;

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state();
        chk("reset_payload", dut_pay(), 128'd0);

        // ADDI x5,x1,-1
        drive(1, 32'hFFF08293, 32'd10, 32'd99, 1, 0);
        step(acc);
        chk("addi_valid", 128'(out_valid), 128'd1);
        chk("addi_fields", 128'({out_alu_sel, out_funct3, out_x, out_y, out_rd, out_wr_en}),
            128'({1'b1, 3'b000, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b1}));

        // SUB x3,x1,x2
        drive(1, 32'h402081B3, 32'd7, 32'd3, 1, 0);
        step(acc);
        chk("sub_fields", 128'({out_funct7, out_alu_sel, out_x, out_y}),
            128'({7'b0100000, 1'b0, 32'd7, 32'd3}));

        // SRAI x4,x4,3
        drive(1, 32'h40325213, 32'h8000_0000, 32'd0, 1, 0);
        step(acc);
        chk("srai_fields", 128'({out_funct7, out_funct3, out_alu_sel, out_y}),
            128'({7'b0100000, 3'b101, 1'b1, 32'd3}));
        idle(2);

        // Back-to-back with the ALU stalled for three cycles
        ops[0] = 32'h00108093; ops[1] = 32'h002081B3;
        ops[2] = 32'h40208233; ops[3] = 32'h00311293;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            drive(1, ops[idx], 32'd100 + 32'(idx), 32'd200 + 32'(idx), c >= 3, 0);
            step(acc);
            if (acc) idx++;
            if (c == 1) chk("b2b_ready_low", 128'(in_ready), 128'd0);
            if (c == 2) chk("b2b_two_accepts", 128'(idx), 128'd2);
        end
        chk("b2b_all_accepted", 128'(idx), 128'd4);
        idle(3);

        // Illegal encodings and a write to x0
        drive(1, 32'h0000007F, 32'h11, 32'h22, 1, 0);
        step(acc);
        chk("ill_opcode", 128'({out_illegal, out_wr_en, out_x, out_y}), 128'({1'b1, 1'b0, 64'd0}));
        drive(1, 32'h022081B3, 32'h11, 32'h22, 1, 0);
        step(acc);
        chk("ill_funct7", 128'({out_illegal, out_wr_en, out_x, out_y}), 128'({1'b1, 1'b0, 64'd0}));
        drive(1, 32'h00208033, 32'h11, 32'h22, 1, 0);
        step(acc);
        chk("add_x0", 128'({out_illegal, out_wr_en, out_x}), 128'({1'b0, 1'b0, 32'h11}));
        idle(2);

        // Flush with two ops held and a third presented
        drive(1, 32'h00108093, 1, 2, 0, 0); step(acc);
        drive(1, 32'h00208113, 3, 4, 0, 0); step(acc);
        drive(1, 32'h00308193, 5, 6, 1, 1); step(acc);
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_ready", 128'(in_ready), 128'd1);
        idle(3);
        chk("flush_no_ghost", 128'(out_valid), 128'd0);

        // Writeback arriving while ADD x6,x5,x5 is held
        drive(1, 32'h00528333, 32'h55, 32'h55, 0, 0);
        step(acc);
        drive(0, 32'h0, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        step(acc);
`ifdef BYPASS_EN
        chk("bypass_xy", 128'({out_x, out_y}), 128'({32'h1234, 32'h1234}));
`else
        chk("bypass_xy", 128'({out_x, out_y}), 128'({32'h55, 32'h55}));
`endif
        idle(2);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
            wb_valid = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            step(acc);
        end

        // Reset in the middle of traffic
        drive(1, 32'h00108093, 1, 2, 0, 0); step(acc);
        drive(1, 32'h00208113, 3, 4, 0, 0); step(acc);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 128'(out_valid), 128'd0);
        chk("midreset_payload", dut_pay(), 128'd0);
        q.delete();
        drive(0, 32'h0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state();
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
